// File: rtl/lfsr_sequence_checker.sv
// lfsr_sequence_checker: lock onto an 8-bit XNOR LFSR stream, count mispredicted words, flag lockup.
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   valid_i        data_i holds a new LFSR word this cycle
//   data_i         LFSR output word
//   clear_count_i  synchronous clear of err_count_o (wins over an increment)
//   locked_o       checker is tracking the sequence
//   error_pulse_o  one-cycle pulse per mispredicted word while locked
//   err_count_o    saturating count of mispredicted words
//   lockup_o       last valid word was 8'hFF
module lfsr_sequence_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [7:0]       data_i,
    input  logic             clear_count_i,
    output logic             locked_o,
    output logic             error_pulse_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             lockup_o
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(LOSS_COUNT + 1);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t           state_q;
    logic [7:0]       ref_q;
    logic             has_prev_q;
    logic [MW-1:0]    match_q;
    logic [SW-1:0]    miss_q;
    logic             error_pulse_q;
    logic [CNT_W-1:0] err_q;
    logic             lockup_q;
    logic [7:0]       pred;
    logic [MW-1:0]    match_d;
    logic [SW-1:0]    miss_d;
    logic             hit;
    assign pred    = {ref_q[6:0], ~(ref_q[7] ^ ref_q[3])};
    assign hit     = data_i == pred;
    assign match_d = match_q + 1'b1;
    assign miss_d  = miss_q + 1'b1;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SEARCH;
            ref_q         <= '0;
            has_prev_q    <= 1'b0;
            match_q       <= '0;
            miss_q        <= '0;
            error_pulse_q <= 1'b0;
            err_q         <= '0;
            lockup_q      <= 1'b0;
        end else begin
            error_pulse_q <= 1'b0;
            if (valid_i) begin
                lockup_q <= data_i == 8'hFF;
                if (state_q == SEARCH) begin
                    ref_q      <= data_i;
                    has_prev_q <= 1'b1;
                    // FF predicts itself, so it is excluded to keep the checker off the lockup state
                    if (!has_prev_q) begin
                        match_q <= '0;
                    end else if (hit && data_i != 8'hFF) begin
                        if (match_d == MW'(LOCK_COUNT)) begin
                            state_q <= LOCKED;
                            match_q <= '0;
                            miss_q  <= '0;
                        end else begin
                            match_q <= match_d;
                        end
                    end else begin
                        match_q <= '0;
                    end
                end else if (hit) begin
                    ref_q  <= pred;
                    miss_q <= '0;
                end else begin
                    error_pulse_q <= 1'b1;
                    if (err_q != '1) err_q <= err_q + 1'b1;
                    // the reference free-runs so an isolated bad word cannot derail prediction
                    if (miss_d == SW'(LOSS_COUNT)) begin
                        state_q    <= SEARCH;
                        ref_q      <= data_i;
                        has_prev_q <= 1'b1;
                        match_q    <= '0;
                        miss_q     <= '0;
                    end else begin
                        ref_q  <= pred;
                        miss_q <= miss_d;
                    end
                end
            end
            if (clear_count_i) err_q <= '0;
        end
    end
    assign locked_o      = state_q == LOCKED;
    assign error_pulse_o = error_pulse_q;
    assign err_count_o   = err_q;
    assign lockup_o      = lockup_q;
endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// tb_lfsr_sequence_checker: scoreboard bench for lfsr_sequence_checker (16-bit and 2-bit counters).
module tb_lfsr_sequence_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        locked, pulse, lockup, locked2, pulse2, lockup2;
    logic [15:0] err;
    logic [1:0]  err2;
    typedef struct {
        logic l;
        logic p;
        int   e;
        logic k;
    } exp_t;
    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic       lk_exp = 1'b0;
    logic [7:0] x;
    always #5 clk = ~clk;
    lfsr_sequence_checker #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_count_i(clr),
        .locked_o(locked), .error_pulse_o(pulse), .err_count_o(err), .lockup_o(lockup)
    );
    lfsr_sequence_checker #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_count_i(clr),
        .locked_o(locked2), .error_pulse_o(pulse2), .err_count_o(err2), .lockup_o(lockup2)
    );
    function automatic logic [7:0] nx(input logic [7:0] v);
        return {v[6:0], ~(v[7] ^ v[3])};
    endfunction
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_zero(input string tag);
        check_eq({tag, ".locked"}, 32'(locked), 0);
        check_eq({tag, ".pulse"}, 32'(pulse), 0);
        check_eq({tag, ".err"}, 32'(err), 0);
        check_eq({tag, ".lockup"}, 32'(lockup), 0);
        check_eq({tag, ".locked2"}, 32'(locked2), 0);
        check_eq({tag, ".err2"}, 32'(err2), 0);
        check_eq({tag, ".lockup2"}, 32'(lockup2), 0);
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic c, input logic el,
                        input logic ep, input int ee, input string tag);
        exp_t t;
        @(negedge clk);
        valid = v;
        data  = d;
        clr   = c;
        if (v) lk_exp = d == 8'hFF;
        t.l = el;
        t.p = ep;
        t.e = ee;
        t.k = lk_exp;
        sb.push_back(t);
        @(posedge clk);
        #1;
        t = sb.pop_front();
        check_eq({tag, ".locked"}, 32'(locked), 32'(t.l));
        check_eq({tag, ".pulse"}, 32'(pulse), 32'(t.p));
        check_eq({tag, ".err"}, 32'(err), t.e);
        check_eq({tag, ".lockup"}, 32'(lockup), 32'(t.k));
        check_eq({tag, ".locked2"}, 32'(locked2), 32'(t.l));
        check_eq({tag, ".pulse2"}, 32'(pulse2), 32'(t.p));
        check_eq({tag, ".err2"}, 32'(err2), t.e > 3 ? 3 : t.e);
    endtask
    task automatic do_reset(input string tag);
        @(negedge clk);
        valid = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #2;
        check_zero(tag);
        @(negedge clk);
        rst_n  = 1'b1;
        lk_exp = 1'b0;
    endtask
    task automatic seq_lock(input string tag);
        x = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, x, 1'b0, i >= 4, 1'b0, 0, $sformatf("%s_w%0d", tag, i));
            x = nx(x);
        end
    endtask
    initial begin
        do_reset("t1_rst");
        seq_lock("t1");
        step(1'b1, x ^ 8'h01, 1'b0, 1'b1, 1'b1, 1, "t2_bad");
        x = nx(x);
        step(1'b1, x, 1'b0, 1'b1, 1'b0, 1, "t2_good1");
        x = nx(x);
        step(1'b1, x, 1'b0, 1'b1, 1'b0, 1, "t2_good2");
        x = nx(x);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, "t2_idle");
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, "t3_clr");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, x ^ 8'h55, 1'b0, i < 2, 1'b1, i + 1, $sformatf("t3_bad%0d", i));
            x = nx(x);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, x, 1'b0, i == 4, 1'b0, 3, $sformatf("t3_relock%0d", i));
            x = nx(x);
        end
        do_reset("t4_rst");
        for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0, $sformatf("t4_ff%0d", i));
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, "t4_exit");
        do_reset("t5_rst");
        seq_lock("t5");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, x ^ 8'h80, 1'b0, 1'b1, 1'b1, i + 1, $sformatf("t5_bad%0d", i));
            x = nx(x);
            step(1'b1, x, 1'b0, 1'b1, 1'b0, i + 1, $sformatf("t5_good%0d", i));
            x = nx(x);
        end
        step(1'b1, x ^ 8'h80, 1'b1, 1'b1, 1'b1, 0, "t5_clr_bad");
        x = nx(x);
        step(1'b1, x, 1'b0, 1'b1, 1'b0, 0, "t5_after_clr");
        x = nx(x);
        step(1'b1, x ^ 8'h80, 1'b0, 1'b1, 1'b1, 1, "t6_bad1");
        x = nx(x);
        step(1'b1, x, 1'b0, 1'b1, 1'b0, 1, "t6_good");
        x = nx(x);
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 2, "t6_bad_ff");
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        @(negedge clk);
        rst_n  = 1'b1;
        lk_exp = 1'b0;
        seq_lock("t6");
        @(negedge clk);
        valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
